// File: rtl/pic_prog_pkg.sv
// Shared definitions for the PIC programmer datapaths: FSM encodings and the
// UART byte handshake used by both the RX-to-RAM writer and the RAM dumper.
package pic_prog_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    D_IDLE,
    D_RD,
    D_RD_WAIT,
    D_HI,
    D_LO,
    D_CK
  } dump_state_e;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_SEND,
    HS_ACK,
    HS_WAIT
  } hs_state_e;

  // Byte that brings the running byte sum to zero mod 256.
  function automatic logic [BYTE_W-1:0] ck_byte(input logic [BYTE_W-1:0] sum);
    return ~sum + BYTE_W'(1);
  endfunction

endpackage

// File: rtl/uart_tx_handshake.sv
// Pushes one byte through the UART TX strobe/busy handshake:
// wait idle, strobe, wait busy rise, wait busy fall, then pulse byte_done.
module uart_tx_handshake
  import pic_prog_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              send_req,
  input  logic [BYTE_W-1:0] tx_byte,
  input  logic              busy_tx,
  output logic [BYTE_W-1:0] serial_write,
  output logic              start_tx,
  output logic              byte_done
);

  hs_state_e         state, state_d;
  logic [BYTE_W-1:0] byte_hold, byte_hold_d;
  logic [BYTE_W-1:0] serial_write_d;
  logic              start_tx_d;
  logic              byte_done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HS_IDLE;
      byte_hold    <= '0;
      serial_write <= '0;
      start_tx     <= 1'b0;
      byte_done    <= 1'b0;
    end else begin
      state        <= state_d;
      byte_hold    <= byte_hold_d;
      serial_write <= serial_write_d;
      start_tx     <= start_tx_d;
      byte_done    <= byte_done_d;
    end
  end

  always_comb begin
    state_d        = state;
    byte_hold_d    = byte_hold;
    serial_write_d = serial_write;
    start_tx_d     = 1'b0;
    byte_done_d    = 1'b0;
    case (state)
      HS_IDLE: begin
        if (send_req) begin
          byte_hold_d = tx_byte;
          state_d     = HS_SEND;
        end
      end
      HS_SEND: begin
        if (!busy_tx) begin
          start_tx_d     = 1'b1;
          serial_write_d = byte_hold;
          state_d        = HS_ACK;
        end
      end
      HS_ACK: begin
        if (busy_tx) state_d = HS_WAIT;
      end
      HS_WAIT: begin
        if (!busy_tx) begin
          byte_done_d = 1'b1;
          state_d     = HS_IDLE;
        end
      end
      default: state_d = HS_IDLE;
    endcase
    // A byte already strobed finishes in the UART; only our sequencing stops.
    if (abort) begin
      state_d     = HS_IDLE;
      start_tx_d  = 1'b0;
      byte_done_d = 1'b0;
    end
  end

endmodule

// File: rtl/mem_uart_dumper.sv
// Walks a range of program-word RAM and streams each word to the UART TX as
// high byte then low byte, followed by a checksum byte zeroing the byte sum.
module mem_uart_dumper
  import pic_prog_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 14
) (
  input  logic              CLK_UART_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   count_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              mem_re_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [7:0]        serial_write_o,
  output logic              start_tx_o,
  input  logic              busy_tx_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  dump_state_e       state, state_d;
  logic [ADDR_W-1:0] ptr, ptr_d;
  logic [CNT_W-1:0]  remaining, remaining_d;
  logic [BYTE_W-1:0] csum, csum_d;
  logic [BYTE_W-1:0] word_lo, word_lo_d;
  logic              mem_re_d;
  logic              busy_d;
  logic              done_d;

  logic              send_req_c;
  logic [BYTE_W-1:0] tx_byte_c;
  logic              byte_done;

  assign addr_o = ptr;

  uart_tx_handshake u_hs (
    .clk          (CLK_UART_i),
    .rst_n        (rst_n_i),
    .abort        (abort_i),
    .send_req     (send_req_c),
    .tx_byte      (tx_byte_c),
    .busy_tx      (busy_tx_i),
    .serial_write (serial_write_o),
    .start_tx     (start_tx_o),
    .byte_done    (byte_done)
  );

  always_ff @(posedge CLK_UART_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= D_IDLE;
      ptr       <= '0;
      remaining <= '0;
      csum      <= '0;
      word_lo   <= '0;
      mem_re_o  <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      remaining <= remaining_d;
      csum      <= csum_d;
      word_lo   <= word_lo_d;
      mem_re_o  <= mem_re_d;
      busy_o    <= busy_d;
      done_o    <= done_d;
    end
  end

  // The high byte is handed off straight from the RAM data so only the low byte is kept.
  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    remaining_d = remaining;
    csum_d      = csum;
    word_lo_d   = word_lo;
    done_d      = 1'b0;
    send_req_c  = 1'b0;
    tx_byte_c   = '0;
    case (state)
      D_IDLE: begin
        if (start_i) begin
          ptr_d       = base_addr_i;
          remaining_d = count_i;
          csum_d      = '0;
          if (count_i == '0) begin
            send_req_c = 1'b1;
            tx_byte_c  = ck_byte('0);
            state_d    = D_CK;
          end else begin
            state_d = D_RD;
          end
        end
      end
      D_RD: state_d = D_RD_WAIT;
      D_RD_WAIT: begin
        word_lo_d  = mem_data_i[7:0];
        send_req_c = 1'b1;
        tx_byte_c  = BYTE_W'(mem_data_i[DATA_W-1:8]);
        csum_d     = csum + tx_byte_c;
        state_d    = D_HI;
      end
      D_HI: begin
        if (byte_done) begin
          send_req_c = 1'b1;
          tx_byte_c  = word_lo;
          csum_d     = csum + tx_byte_c;
          state_d    = D_LO;
        end
      end
      D_LO: begin
        if (byte_done) begin
          ptr_d       = ptr + ADDR_W'(1);
          remaining_d = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            send_req_c = 1'b1;
            tx_byte_c  = ck_byte(csum);
            state_d    = D_CK;
          end else begin
            state_d = D_RD;
          end
        end
      end
      D_CK: begin
        if (byte_done) begin
          done_d  = 1'b1;
          state_d = D_IDLE;
        end
      end
      default: state_d = D_IDLE;
    endcase
    // Abort beats everything, including a start arriving in the same cycle.
    if (abort_i) begin
      state_d     = D_IDLE;
      ptr_d       = ptr;
      remaining_d = remaining;
      csum_d      = csum;
      send_req_c  = 1'b0;
      done_d      = 1'b0;
    end
    mem_re_d = (state_d == D_RD);
    busy_d   = (state_d != D_IDLE);
  end

endmodule

// File: tb/tb_mem_uart_dumper.sv
// Self-checking bench for mem_uart_dumper: directed vectors, corner sequences
// and randomized dumps compared against a byte-stream reference model.
module tb_mem_uart_dumper;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, mem_re, start_tx, busy_tx, busy, done;
  logic [7:0]  base, addr, serial;
  logic [8:0]  count;
  logic [13:0] mem_data;

  logic [13:0] ram [256];
  int          ucnt = 0;
  int          onset = 0;
  int          blen = 2;
  int          dones = 0;
  int          overlap = 0;
  logic [7:0]  tx_q [$];
  logic [7:0]  re_q [$];
  logic [7:0]  exp_b [$];
  logic [7:0]  exp_a [$];
  int          last_tx0;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic [7:0]  base;
    logic [8:0]  count;
    logic [13:0] w0;
    logic [13:0] w1;
    int          nb;
    logic [39:0] eb;
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  mem_uart_dumper dut (
    .CLK_UART_i     (clk),
    .rst_n_i        (rst_n),
    .start_i        (start),
    .base_addr_i    (base),
    .count_i        (count),
    .abort_i        (abort),
    .addr_o         (addr),
    .mem_re_o       (mem_re),
    .mem_data_i     (mem_data),
    .serial_write_o (serial),
    .start_tx_o     (start_tx),
    .busy_tx_i      (busy_tx),
    .busy_o         (busy),
    .done_o         (done)
  );

  // UART: busy rises `onset` cycles after a strobe and lasts `blen` cycles.
  assign busy_tx = (ucnt != 0) && (ucnt <= blen);

  always @(posedge clk) begin
    if (start_tx) begin
      tx_q.push_back(serial);
      if (busy_tx) overlap++;
      ucnt <= onset + blen;
    end else if (ucnt != 0) begin
      ucnt <= ucnt - 1;
    end
    if (mem_re) begin
      re_q.push_back(addr);
      mem_data <= ram[addr];
    end
    if (done) dones++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model(input int b, input int c);
    int sum;
    sum = 0;
    exp_b.delete();
    exp_a.delete();
    for (int i = 0; i < c; i++) begin
      int a;
      int w;
      a = (b + i) % 256;
      w = int'(ram[a]);
      exp_a.push_back(8'(a));
      exp_b.push_back(8'(w / 256));
      exp_b.push_back(8'(w % 256));
      sum += w / 256 + w % 256;
    end
    exp_b.push_back(8'((256 - sum % 256) % 256));
  endtask

  task automatic wait_uart_idle();
    for (int i = 0; i < 1000 && ucnt != 0; i++) tick();
    if (ucnt != 0) chk("uart idle wait", longint'(ucnt), 0);
  endtask

  task automatic run_dump(input int b, input int c, input bit inject, input string nm);
    int tx0, re0, d0, cyc, budget, mism;
    bit injected;
    injected = 1'b0;
    model(b, c);
    wait_uart_idle();
    tx0 = tx_q.size();
    re0 = re_q.size();
    d0 = dones;
    last_tx0 = tx0;
    base = 8'(b);
    count = 9'(c);
    start = 1'b1;
    tick();
    start = 1'b0;
    base = ~8'(b);
    count = 9'($urandom_range(0, 511));
    budget = 100 + (2 * c + 1) * (onset + blen + 12);
    cyc = 0;
    while (dones == d0 && cyc < budget) begin
      if (inject && !injected && tx_q.size() == tx0 + 1) begin
        base = 8'(b + 37);
        count = 9'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        injected = 1'b1;
      end else begin
        tick();
      end
      cyc++;
    end
    chk({nm, " timeout"}, longint'(cyc < budget), 1);
    repeat (4) tick();
    chk({nm, " done pulses"}, longint'(dones - d0), 1);
    chk({nm, " byte count"}, longint'(tx_q.size() - tx0), longint'(exp_b.size()));
    mism = 0;
    foreach (exp_b[i])
      if (tx0 + i >= tx_q.size() || tx_q[tx0 + i] != exp_b[i]) mism++;
    chk({nm, " byte mismatches"}, longint'(mism), 0);
    chk({nm, " read count"}, longint'(re_q.size() - re0), longint'(exp_a.size()));
    mism = 0;
    foreach (exp_a[i])
      if (re0 + i >= re_q.size() || re_q[re0 + i] != exp_a[i]) mism++;
    chk({nm, " addr mismatches"}, longint'(mism), 0);
    chk({nm, " busy low after"}, longint'(busy), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int tx0, d0, re0, cyc;
    logic [7:0] got;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    base = '0;
    count = '0;
    for (int i = 0; i < 256; i++) ram[i] = 14'($urandom);

    vecs[0] = '{8'h10, 9'd2, 14'h3FFF, 14'h0123, 5, 40'h3FFF01239E};
    vecs[1] = '{8'h55, 9'd0, 14'h0000, 14'h0000, 1, 40'h0000000000};
    vecs[2] = '{8'hFF, 9'd2, 14'h0001, 14'h0002, 5, 40'h00010002FD};
    vecs[3] = '{8'h80, 9'd1, 14'h2A5C, 14'h0000, 3, 40'h2A5C7A0000};

    #3;
    chk("reset outputs", longint'({busy, done, start_tx, mem_re, serial, addr}), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Directed vectors with hand-computed byte streams.
    onset = 0;
    blen = 3;
    foreach (vecs[v]) begin
      ram[vecs[v].base] = vecs[v].w0;
      ram[8'(vecs[v].base + 8'd1)] = vecs[v].w1;
      run_dump(int'(vecs[v].base), int'(vecs[v].count), 1'b0, $sformatf("vec%0d", v));
      for (int k = 0; k < vecs[v].nb; k++) begin
        got = (last_tx0 + k < tx_q.size()) ? tx_q[last_tx0 + k] : 8'hXX;
        chk($sformatf("vec%0d byte%0d", v, k), longint'(got), longint'(vecs[v].eb[39 - 8 * k -: 8]));
      end
    end

    // Slow UART: late busy onset and long busy.
    onset = 3;
    blen = 100;
    tx0 = tx_q.size();
    run_dump(16, 2, 1'b0, "slow uart");
    chk("slow uart strobes", longint'(tx_q.size() - tx0), 5);
    chk("slow uart overlap", longint'(overlap), 0);

    // Start pulsed mid-dump with another base must be ignored.
    onset = 1;
    blen = 4;
    run_dump(32, 3, 1'b1, "mid start");

    // Start and abort together in IDLE: abort wins.
    re0 = re_q.size();
    base = 8'h33;
    count = 9'd4;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    repeat (5) tick();
    chk("start+abort busy", longint'(busy), 0);
    chk("start+abort reads", longint'(re_q.size() - re0), 0);

    // Abort during WAIT_LO of the first word.
    onset = 0;
    blen = 20;
    wait_uart_idle();
    tx0 = tx_q.size();
    d0 = dones;
    base = 8'h40;
    count = 9'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (tx_q.size() != tx0 + 2 && cyc < 500) begin
      tick();
      cyc++;
    end
    chk("abort reach lo", longint'(cyc < 500), 1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort outputs", longint'({busy, start_tx, mem_re, done}), 0);
    repeat (60) tick();
    chk("abort strobes", longint'(tx_q.size() - tx0), 2);
    chk("abort no done", longint'(dones - d0), 0);
    run_dump(195, 2, 1'b0, "after abort");

    // Async reset while waiting for busy after the high byte strobe.
    onset = 3;
    blen = 5;
    wait_uart_idle();
    tx0 = tx_q.size();
    base = 8'h70;
    count = 9'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (tx_q.size() != tx0 + 1 && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("reset reach ack", longint'(cyc < 200), 1);
    rst_n = 1'b0;
    #1;
    chk("async reset outputs", longint'({busy, done, start_tx, mem_re, serial, addr}), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    run_dump(113, 2, 1'b0, "after reset");

    // Randomized dumps against the reference model.
    for (int r = 0; r < 8; r++) begin
      onset = $urandom_range(0, 3);
      blen = $urandom_range(1, 6);
      for (int i = 0; i < 256; i++) ram[i] = 14'($urandom);
      run_dump($urandom_range(0, 255), $urandom_range(0, 5), 1'b0, $sformatf("rand%0d", r));
    end

    // Entire RAM in one dump.
    onset = 0;
    blen = 1;
    run_dump($urandom_range(0, 255), 256, 1'b0, "full ram");

    chk("no strobe while busy", longint'(overlap), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_uart_dumper.md
Name: mem_uart_dumper

Overview:
- Read-back engine for the programmer: walks a range of the program-word RAM and streams each word to the UART transmitter as two bytes, high byte first.
- Sends a trailing checksum byte after the last word.
- Sits between the word RAM (read port) and the UART TX (serial_write/start_tx/busy_tx handshake).
- Mirror of the RX-to-RAM write path, so the host can verify what was loaded.

Parameters:
- ADDR_W, 8, RAM address width; word count range 0..2^ADDR_W.
- DATA_W, 14, RAM word width (PIC14 instruction word); legal range 9..16.

Ports:
- CLK_UART_i  in  1  system clock; all state on rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  one-cycle request to begin a dump; ignored while busy_o=1.
- base_addr_i  in  ADDR_W  first word address; sampled when start_i is accepted.
- count_i  in  ADDR_W+1  number of words; sampled when start_i is accepted.
- abort_i  in  1  cancel the dump in progress.
- addr_o  out  ADDR_W  RAM read address.
- mem_re_o  out  1  RAM read enable; data is valid on mem_data_i one cycle later.
- mem_data_i  in  DATA_W  RAM read data.
- serial_write_o  out  8  byte to the UART TX.
- start_tx_o  out  1  one-cycle transmit strobe.
- busy_tx_i  in  1  UART TX busy.
- busy_o  out  1  dump in progress.
- done_o  out  1  one-cycle pulse when the checksum byte has finished transmitting.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; checksum register 0.
- State: ptr, remaining, csum[7:0], word_reg.

FSM states and transitions:
- IDLE: on start_i, latch ptr=base_addr_i and remaining=count_i, clear csum, set busy_o=1.
  - If count_i=0, go to SEND_CK.
  - Otherwise go to RD.
- RD: addr_o=ptr, mem_re_o=1 for exactly one cycle; go to RD_WAIT.
- RD_WAIT: capture mem_data_i into word_reg; go to SEND_HI.
- SEND_HI: wait until busy_tx_i=0.
  - Drive serial_write_o = zero-extended word_reg[DATA_W-1:8].
  - Pulse start_tx_o for one cycle; csum += byte.
  - Go to ACK_HI.
- ACK_HI: wait for busy_tx_i=1, then go to WAIT_HI.
- WAIT_HI: wait for busy_tx_i=0, then go to SEND_LO.
- SEND_LO, ACK_LO, WAIT_LO: same handshake with byte word_reg[7:0].
  - After WAIT_LO: ptr += 1 (mod 2^ADDR_W), remaining -= 1.
  - If remaining is now 0, go to SEND_CK; otherwise go to RD.
- SEND_CK, ACK_CK, WAIT_CK: send byte (-csum) mod 256, so that the sum of all sent bytes is 0 mod 256.
  - Completion: done_o=1 for one cycle, busy_o=0, back to IDLE.

Handshake rules:
- serial_write_o is held stable from the start_tx_o pulse until the next start_tx_o pulse.
- start_tx_o is never asserted while busy_tx_i=1.

Boundary conditions:
- Address wrap: ptr wraps past 2^ADDR_W-1 to 0, no error.
- count_i=2^ADDR_W: dumps the entire RAM once.
- abort_i, any non-IDLE state:
  - Next cycle the FSM is in IDLE with busy_o=0, start_tx_o=0, mem_re_o=0, and no done_o.
  - A byte already handed to the UART completes on its own.
- abort_i and start_i in the same cycle in IDLE: abort wins, start is dropped.
- start_i while busy: ignored; latched parameters are unchanged.
- Async reset mid-dump: immediate return to the reset values.
- Throughput: one RAM read per word; 2 idle cycles of overhead per word beyond UART time.

Decomposition:
- Shared package (pic_prog_pkg): FSM state encoding localparams, and the UART byte handshake constants shared with the RX-to-RAM writer.
- One sub-module, uart_tx_handshake: takes a byte plus a send request, performs the SEND/ACK/WAIT sequence against busy_tx_i, and returns a one-cycle byte_done. It is instantiated once and reused for the HI, LO and CK bytes.

Test Plan:
- RAM[0x10]=0x3FFF, RAM[0x11]=0x0123; start, base=0x10, count=2.
  - Required: TX bytes 0x3F,0xFF,0x01,0x23,0x9E.
  - Required: done_o pulses exactly once, after the last busy_tx fall.
- count=0, base=0x55: no mem_re_o pulses; single TX byte 0x00; done_o pulses.
- Wrap: base=0xFF, count=2, RAM[0xFF]=0x0001, RAM[0x00]=0x0002.
  - Required: addr_o sequence 0xFF then 0x00.
  - Required: bytes 0x00,0x01,0x00,0x02,0xFD.
- UART model with 3-cycle busy onset latency and 100-cycle busy: start_tx_o never overlaps busy; exactly 5 strobes for count=2.
- abort_i asserted during WAIT_LO of word 0: busy_o=0 on the next cycle, no further start_tx_o, no done_o. A new start then dumps correctly from its own base.
- start_i pulsed mid-dump with a different base: ignored; output stream is identical to the uninterrupted run.
- rst_n_i asserted during ACK_HI: all outputs 0 asynchronously. After release, a fresh dump behaves normally.
